// File: rtl/decode_buffer.sv
// -----------------------------------------------------------------------------
// decode_buffer
//
// Decoding instruction buffer placed between fetch and the issue queue.
// Up to FETCH_WIDTH fetched instructions per cycle are decoded when they are
// written and are held in a circular buffer of DEPTH entries. The oldest
// ISSUE_WIDTH entries are presented, in program order, to the issue queue.
// A flush (branch mispredict) empties the buffer and drops the incoming group.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset (control state only)
//   flush      in   discard all buffered and incoming instructions
//   in_valid   in   [FETCH_WIDTH]  per-lane valid, lanes need not be contiguous
//   in_req     in   [FETCH_WIDTH*97] per lane {pc, inst, predict_pc_addr,
//                   predict_brunch_taken}, lane 0 in the low bits
//   in_ready   out  room for a full fetch group (registered count only)
//   out_valid  out  [ISSUE_WIDTH] thermometer code, lane 0 = oldest
//   out_elem   out  [ISSUE_WIDTH*195] decoded elements, lane 0 in the low bits
//   out_take   in   lanes consumed this cycle, <= popcount(out_valid)
//   occupancy  out  current entry count
//
// Decoded element layout (MSB first, 195 bits):
//   pc[32] predict_pc_addr[32] predict_brunch_taken[1]
//   num1[32] num1_needed[1] num1_reg_addr[5]
//   num2[32] num2_needed[1] num2_reg_addr[5]
//   memory_addr_offset[32] accept_mask[3] inst_type[2]
//   alu_op[3] llu_op[2] brunch_type[2] mem_type[2]
//   mem_read_ena[1] mem_write_ena[1] write_reg[1] write_reg_addr[5]
// Encodings:
//   inst_type   : 0 arithmatic, 1 brunch
//   alu_op      : 0 nop, 1 add, 2 sub, 3 and, 4 or
//   llu_op      : 0 nop, 1 eq, 2 neq
//   brunch_type : 0 nbc, 1 j, 2 b
//   mem_type    : 0 wrd
// -----------------------------------------------------------------------------
module decode_buffer #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8,
  localparam int REQ_W      = 97,
  localparam int ELEM_W     = 195
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [FETCH_WIDTH-1:0]             in_valid,
  input  logic [FETCH_WIDTH*REQ_W-1:0]       in_req,
  output logic                               in_ready,
  output logic [ISSUE_WIDTH-1:0]             out_valid,
  output logic [ISSUE_WIDTH*ELEM_W-1:0]      out_elem,
  input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   out_take,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  // Pointer mask keeps indices legal even in the degenerate DEPTH=1 case.
  localparam logic [PW-1:0] PMASK = PW'(DEPTH - 1);
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - FETCH_WIDTH);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;

  localparam logic [1:0] TYPE_ARITH  = 2'd0;
  localparam logic [1:0] TYPE_BRUNCH = 2'd1;
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [1:0] LLU_NOP = 2'd0;
  localparam logic [1:0] LLU_EQ  = 2'd1;
  localparam logic [1:0] LLU_NEQ = 2'd2;
  localparam logic [1:0] BR_NBC  = 2'd0;
  localparam logic [1:0] BR_J    = 2'd1;
  localparam logic [1:0] BR_B    = 2'd2;
  localparam logic [1:0] MEM_WRD = 2'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] predict_pc_addr;
    logic        predict_brunch_taken;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] predict_pc_addr;
    logic        predict_brunch_taken;
    logic [31:0] num1;
    logic        num1_needed;
    logic [4:0]  num1_reg_addr;
    logic [31:0] num2;
    logic        num2_needed;
    logic [4:0]  num2_reg_addr;
    logic [31:0] memory_addr_offset;
    logic [2:0]  accept_mask;
    logic [1:0]  inst_type;
    logic [2:0]  alu_op;
    logic [1:0]  llu_op;
    logic [1:0]  brunch_type;
    logic [1:0]  mem_type;
    logic        mem_read_ena;
    logic        mem_write_ena;
    logic        write_reg;
    logic [4:0]  write_reg_addr;
  } elem_t;

  // Single-instruction decoder. Everything not touched by an opcode keeps
  // the NOP defaults set at the top.
  function automatic elem_t decode(input req_t r);
    elem_t       e;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] simm;
    logic [31:0] pc4;
    logic        is_r;
    logic [2:0]  r_alu;
    op   = r.inst[31:26];
    fn   = r.inst[5:0];
    rs   = r.inst[25:21];
    rt   = r.inst[20:16];
    rd   = r.inst[15:11];
    simm = {{16{r.inst[15]}}, r.inst[15:0]};
    pc4  = r.pc + 32'd4;
    is_r  = 1'b0;
    r_alu = ALU_NOP;

    e                      = '0;
    e.pc                   = r.pc;
    e.predict_pc_addr      = r.predict_pc_addr;
    e.predict_brunch_taken = r.predict_brunch_taken;
    e.accept_mask          = 3'b111;
    e.inst_type            = TYPE_ARITH;
    e.alu_op               = ALU_NOP;
    e.llu_op               = LLU_NOP;
    e.brunch_type          = BR_NBC;
    e.mem_type             = MEM_WRD;

    case (op)
      OP_ORI, OP_ADDIU: begin
        e.num1_needed    = 1'b1;
        e.num1_reg_addr  = rs;
        e.num2           = simm;
        e.alu_op         = (op == OP_ORI) ? ALU_OR : ALU_ADD;
        e.write_reg      = 1'b1;
        e.write_reg_addr = rt;
      end
      OP_LUI: begin
        e.num2           = {r.inst[15:0], 16'b0};
        e.alu_op         = ALU_OR;
        e.write_reg      = 1'b1;
        e.write_reg_addr = rt;
      end
      OP_SPECIAL: begin
        case (fn)
          FN_ADDU: begin is_r = 1'b1; r_alu = ALU_ADD; end
          FN_SUBU: begin is_r = 1'b1; r_alu = ALU_SUB; end
          FN_AND:  begin is_r = 1'b1; r_alu = ALU_AND; end
          FN_OR:   begin is_r = 1'b1; r_alu = ALU_OR;  end
          default: begin is_r = 1'b0; r_alu = ALU_NOP; end
        endcase
        if (is_r) begin
          e.num1_needed    = 1'b1;
          e.num1_reg_addr  = rs;
          e.num2_needed    = 1'b1;
          e.num2_reg_addr  = rt;
          e.alu_op         = r_alu;
          e.write_reg      = 1'b1;
          e.write_reg_addr = rd;
        end
      end
      OP_LW: begin
        e.num1_needed        = 1'b1;
        e.num1_reg_addr      = rs;
        e.memory_addr_offset = simm;
        e.mem_read_ena       = 1'b1;
        e.alu_op             = ALU_ADD;
        e.write_reg          = 1'b1;
        e.write_reg_addr     = rt;
      end
      OP_SW: begin
        e.num1_needed        = 1'b1;
        e.num1_reg_addr      = rs;
        e.num2_needed        = 1'b1;
        e.num2_reg_addr      = rt;
        e.memory_addr_offset = simm;
        e.mem_write_ena      = 1'b1;
      end
      OP_J, OP_JAL: begin
        e.inst_type   = TYPE_BRUNCH;
        e.brunch_type = BR_J;
        e.num2        = {pc4[31:28], r.inst[25:0], 2'b00};
        if (op == OP_JAL) begin
          // Link value is produced here, so no register operand is needed.
          e.num1           = r.pc + 32'd8;
          e.write_reg      = 1'b1;
          e.write_reg_addr = 5'd31;
        end
      end
      OP_BEQ, OP_BNE: begin
        e.inst_type          = TYPE_BRUNCH;
        e.brunch_type        = BR_B;
        e.llu_op             = (op == OP_BEQ) ? LLU_EQ : LLU_NEQ;
        e.num1_needed        = 1'b1;
        e.num1_reg_addr      = rs;
        e.num2_needed        = 1'b1;
        e.num2_reg_addr      = rt;
        e.memory_addr_offset = pc4 + {simm[29:0], 2'b00};
      end
      default: begin
        e.alu_op = ALU_NOP;
      end
    endcase
    return e;
  endfunction

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  elem_t         r_mem [DEPTH];

  logic          w_wr_en;
  logic [CW-1:0] w_wr_cnt;
  logic [PW-1:0] w_slot [FETCH_WIDTH];
  elem_t         w_dec  [FETCH_WIDTH];

  assign in_ready  = (r_count <= READY_MAX);
  assign occupancy = r_count;
  assign w_wr_en   = in_ready && (|in_valid) && !flush;

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_dec
      assign w_dec[gi] = decode(in_req[gi*REQ_W +: REQ_W]);
    end
  endgenerate

  // Compact valid lanes: each valid lane lands at tail + (number of valid
  // lanes below it), so gaps in in_valid never leave holes in the buffer.
  always_comb begin
    logic [CW-1:0] acc;
    acc = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      w_slot[i] = (r_tail + PW'(acc)) & PMASK;
      acc       = acc + CW'(in_valid[i]);
    end
    w_wr_cnt = w_wr_en ? acc : '0;
  end

  // ---- write stage: storage (data, not reset) ----
  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (w_wr_en && in_valid[i]) begin
        r_mem[w_slot[i]] <= w_dec[i];
      end
    end
  end

  // ---- write/read stage: pointers and count ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= (r_head + PW'(out_take)) & PMASK;
      r_tail  <= (r_tail + PW'(w_wr_cnt)) & PMASK;
      r_count <= r_count + w_wr_cnt - CW'(out_take);
    end
  end

  // ---- read side: combinational view of the oldest entries ----
  genvar gk;
  generate
    for (gk = 0; gk < ISSUE_WIDTH; gk++) begin : g_out
      logic [PW-1:0] w_rd_idx;
      assign w_rd_idx                       = (r_head + PW'(gk)) & PMASK;
      assign out_elem[gk*ELEM_W +: ELEM_W]  = r_mem[w_rd_idx];
      assign out_valid[gk]                  = (r_count > CW'(gk));
    end
  endgenerate

endmodule
